// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC sequencer for the single-cycle MIPS datapath; optional branch delay slot via PC_DELAY_SLOT_EN
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instruction,
  input  logic        rs_eq_rt,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic [31:0] count_d;
  logic [5:0]  opcode;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] taken_target;
  logic        is_halt;
  logic        taken;

`ifdef PC_DELAY_SLOT_EN
  logic        pend_q, pend_d;
  logic [31:0] pend_target_q, pend_target_d;
`endif

  // Decode the fetched instruction and form the candidate targets
  always_comb begin
    opcode        = instruction[31:26];
    pc_plus4      = pc + 32'd4;
    branch_target = pc_plus4 + {{14{instruction[15]}}, instruction[15:0], 2'b00};
    jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};
    is_halt       = (opcode == OP_HALT);
    taken         = 1'b0;
    taken_target  = branch_target;
    case (opcode)
      OP_BEQ:  taken = rs_eq_rt;
      OP_BNE:  taken = !rs_eq_rt;
      OP_J: begin
        taken        = 1'b1;
        taken_target = jump_target;
      end
      default: taken = 1'b0;
    endcase
  end

  // Next state, next PC and retire count; everything holds unless RUN retires
  always_comb begin
    state_d = state_q;
    pc_d    = pc;
    count_d = instr_count;
`ifdef PC_DELAY_SLOT_EN
    pend_d        = pend_q;
    pend_target_d = pend_target_q;
`endif
    case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        if (!stall) begin
          count_d = instr_count + 32'd1;
          if (is_halt) begin
            // pc stays on the halt instruction; a pending slot target is dropped
            state_d = HALT;
`ifdef PC_DELAY_SLOT_EN
            pend_d  = 1'b0;
`endif
          end
`ifdef PC_DELAY_SLOT_EN
          else if (pend_q) begin
            // delay slot retiring: pending target wins over any branch in the slot
            pc_d   = pend_target_q;
            pend_d = 1'b0;
          end
          else if (taken) begin
            pc_d          = pc_plus4;
            pend_d        = 1'b1;
            pend_target_d = taken_target;
          end
`else
          else if (taken) begin
            pc_d = taken_target;
          end
`endif
          else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: state_d = state_q;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc          <= RESET_PC;
      instr_count <= 32'd0;
`ifdef PC_DELAY_SLOT_EN
      pend_q        <= 1'b0;
      pend_target_q <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      instr_count <= count_d;
`ifdef PC_DELAY_SLOT_EN
      pend_q        <= pend_d;
      pend_target_q <= pend_target_d;
`endif
    end
  end

  assign pc_valid = (state_q == RUN);
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit against a behavioural sequencer model
`timescale 1ns/1ps
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] HLT    = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        rs_eq_rt = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        halted;
  logic [31:0] instr_count;

  pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .instruction(instruction),
    .rs_eq_rt(rs_eq_rt),
    .pc(pc),
    .pc_valid(pc_valid),
    .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        halted;
    logic [31:0] count;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  // behavioural model: what the sequencer should look like after each edge
  logic [31:0] m_pc = RST_PC;
  logic [31:0] m_cnt = 32'd0;
  bit          m_idle = 1'b0;
  bit          m_run = 1'b0;
  bit          m_halt = 1'b0;
`ifdef PC_DELAY_SLOT_EN
  bit          m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'd0;
`endif

  task automatic model_step(input bit rst, input bit st, input logic [31:0] ins, input bit eq);
    logic [31:0] p4;
    logic [31:0] tgt;
    logic [5:0]  op;
    int          off;
    bit          take;
    if (rst) begin
      m_pc = RST_PC; m_cnt = 0; m_idle = 1; m_run = 0; m_halt = 0;
`ifdef PC_DELAY_SLOT_EN
      m_pend = 0;
`endif
      return;
    end
    if (m_idle) begin
      m_idle = 0; m_run = 1;
      return;
    end
    if (!m_run || st) return;
    op    = ins[31:26];
    p4    = m_pc + 32'd4;
    m_cnt = m_cnt + 32'd1;
    take  = (op == 6'd4 && eq) || (op == 6'd5 && !eq) || (op == 6'd2);
    off   = $signed(ins[15:0]);
    if (op == 6'd2) tgt = {p4[31:28], ins[25:0], 2'b00};
    else            tgt = p4 + 32'(off * 4);
    if (op == 6'h3F) begin
      m_run = 0; m_halt = 1;
`ifdef PC_DELAY_SLOT_EN
      m_pend = 0;
`endif
    end
`ifdef PC_DELAY_SLOT_EN
    else if (m_pend) begin m_pc = m_ptgt; m_pend = 0; end
    else if (take) begin m_ptgt = tgt; m_pend = 1; m_pc = p4; end
`else
    else if (take) m_pc = tgt;
`endif
    else m_pc = p4;
  endtask

  // drive one cycle of stimulus and queue the expected post-edge outputs
  task automatic cyc(input bit rst, input bit st, input logic [31:0] ins, input bit eq);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = st; instruction = ins; rs_eq_rt = eq;
    model_step(rst, st, ins, eq);
    e.pc = m_pc; e.valid = m_run; e.halted = m_halt; e.count = m_cnt;
    sb.push_back(e);
  endtask

  task automatic run(input logic [31:0] ins, input bit eq);
    cyc(1'b0, 1'b0, ins, eq);
  endtask

  // taken control transfer; with a delay slot, follow it with a NOP slot
  task automatic take_ctl(input logic [31:0] ins, input bit eq);
    run(ins, eq);
`ifdef PC_DELAY_SLOT_EN
    run(NOP, 1'b0);
`endif
  endtask

  function automatic logic [31:0] mk_j(input logic [31:0] addr);
    return {6'b000010, addr[27:2]};
  endfunction

  function automatic logic [31:0] mk_br(input logic [5:0] op, input logic [15:0] imm);
    return {op, 10'd0, imm};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // monitor: pop one expectation per edge and compare every output
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("pc", pc, e.pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.valid});
        chk("halted", {31'd0, halted}, {31'd0, e.halted});
        chk("instr_count", instr_count, e.count);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [5:0]  op;
    int          k;
    bit          st;
    bit          rst;

    // reset for three cycles, then a NOP stream: IDLE, then 100, 104, 108
    repeat (3) cyc(1'b1, 1'b0, NOP, 1'b0);
    repeat (5) run(NOP, 1'b0);

    // beq back to itself, untaken beq, bne forward
    take_ctl(mk_j(32'h200), 1'b0);
    take_ctl(mk_br(6'b000100, 16'hFFFF), 1'b1);
    run(mk_br(6'b000100, 16'hFFFF), 1'b0);
    take_ctl(mk_br(6'b000101, 16'h0003), 1'b0);

    // wrap into the top region with a negative branch, then jump within it
    take_ctl(mk_j(32'h10), 1'b0);
    take_ctl(mk_br(6'b000100, 16'hFFF0), 1'b1);
    take_ctl(mk_j(32'hF000_0010), 1'b0);
    take_ctl(mk_j(32'hF000_0100), 1'b0);

    // branch at 40 to 80 with a jump sitting in the following slot
    take_ctl(mk_j(32'h40), 1'b0);
    run(mk_br(6'b000100, 16'd15), 1'b1);
    run(mk_j(32'h300), 1'b0);
    run(NOP, 1'b0);

    // two stalled cycles with a taken branch presented at 8
    take_ctl(mk_j(32'h8), 1'b0);
    repeat (2) cyc(1'b0, 1'b1, mk_br(6'b000100, 16'd4), 1'b1);
    take_ctl(mk_br(6'b000100, 16'd4), 1'b1);

    // halt at C, stall toggling in HALT, then a one-cycle reset
    take_ctl(mk_j(32'hC), 1'b0);
    run(HLT, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, i[0], NOP, 1'b0);
    cyc(1'b1, 1'b0, NOP, 1'b0);
    repeat (3) run(NOP, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1: op = 6'b000100;
        2, 3: op = 6'b000101;
        4:    op = 6'b000010;
        5:    op = ($urandom_range(0, 3) == 0) ? 6'h3F : 6'd0;
        default: op = 6'($urandom_range(6, 62));
      endcase
      ins = {op, 26'($urandom)};
      st  = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 99) == 0) || (m_halt && $urandom_range(0, 5) == 0);
      cyc(rst, st, ins, 1'($urandom_range(0, 1)));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
